mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of an async SRAM: SETUP, STROBE (WAIT_STATES+1), DONE.
// Request-to-ack latency WAIT_STATES+2 cycles; requesters wait (req held) while busy, one access in flight.
module mem_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_e;

  localparam logic [2:0] WS_CNT = 3'(WAIT_STATES);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        last_grant_q;
  logic        gnt_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        oe_n_q;
  logic        we_n_q;
  logic        m0_ack_q;
  logic        m1_ack_q;
  logic [7:0]  m0_rdata_q;
  logic [7:0]  m1_rdata_q;

  logic        req_any_d;
  logic        grant_d;
  logic        sel_we_d;
  logic [15:0] sel_addr_d;
  logic [7:0]  sel_wdata_d;

  // On a tie the port that did not win last time is granted (grant_d=1 selects m1).
  always_comb begin
    req_any_d   = m0_req | m1_req;
    grant_d     = m1_req & (~m0_req | ~last_grant_q);
    sel_we_d    = grant_d ? m1_we    : m0_we;
    sel_addr_d  = grant_d ? m1_addr  : m0_addr;
    sel_wdata_d = grant_d ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= 8'h00;
      m1_rdata_q   <= 8'h00;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any_d) begin
            state_q      <= SETUP;
            gnt_q        <= grant_d;
            last_grant_q <= grant_d;
            we_q         <= sel_we_d;
            addr_q       <= sel_addr_d;
            wdata_q      <= sel_wdata_d;
          end
        end
        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= WS_CNT;
          oe_n_q  <= we_q;
          we_n_q  <= ~we_q;
        end
        STROBE: begin
          if (cnt_q == 3'd0) begin
            state_q <= DONE;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            // Read data is sampled on the same edge that closes the strobe.
            if (!we_q) begin
              if (gnt_q) m1_rdata_q <= mem_rdata;
              else       m0_rdata_q <= mem_rdata;
            end
            if (gnt_q) m1_ack_q <= 1'b1;
            else       m0_ack_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_mem_arbiter;

  logic        cpu_clk;
  logic        cpu_reset_n;

  logic        m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
  logic [15:0] m0_addr, m1_addr, mem_addr;
  logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic        mem_oe_n, mem_we_n, busy;

  logic        z_m0_req, z_m0_we, z_m0_ack, z_m1_req, z_m1_we, z_m1_ack;
  logic [15:0] z_m0_addr, z_m1_addr, z_mem_addr;
  logic [7:0]  z_m0_wdata, z_m1_wdata, z_m0_rdata, z_m1_rdata, z_mem_wdata, z_mem_rdata;
  logic        z_mem_oe_n, z_mem_we_n, z_busy;

  int checks;
  int failures;

  // Memory models: 0x1000 -> 0x8E, 0x2000 -> 0xBE; second instance 0x0010 -> 0x60, 0x0011 -> 0x61.
  assign mem_rdata   = mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h9E;
  assign z_mem_rdata = z_mem_addr[7:0] + 8'h50;

  mem_arbiter #(.WAIT_STATES(1)) dut (
    .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.WAIT_STATES(0)) dut0 (
    .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n),
    .m0_req(z_m0_req), .m0_we(z_m0_we), .m0_addr(z_m0_addr), .m0_wdata(z_m0_wdata),
    .m0_ack(z_m0_ack), .m0_rdata(z_m0_rdata),
    .m1_req(z_m1_req), .m1_we(z_m1_we), .m1_addr(z_m1_addr), .m1_wdata(z_m1_wdata),
    .m1_ack(z_m1_ack), .m1_rdata(z_m1_rdata),
    .mem_addr(z_mem_addr), .mem_oe_n(z_mem_oe_n), .mem_we_n(z_mem_we_n),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata), .busy(z_busy)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic test_reset();
    logic [44:0] got;
    logic [44:0] exp;
    cpu_reset_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 16'h0; m0_wdata = 8'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0; m1_wdata = 8'h0;
    z_m0_req = 1'b0; z_m0_we = 1'b0; z_m0_addr = 16'h0; z_m0_wdata = 8'h0;
    z_m1_req = 1'b0; z_m1_we = 1'b0; z_m1_addr = 16'h0; z_m1_wdata = 8'h0;
    repeat (2) @(posedge cpu_clk);
    #1;
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 8'h0};
    got = {busy, mem_oe_n, mem_we_n, m0_ack, m1_ack, mem_addr, mem_wdata, m0_rdata, m1_rdata};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
    got = {z_busy, z_mem_oe_n, z_mem_we_n, z_m0_ack, z_m1_ack, z_mem_addr, z_mem_wdata, z_m0_rdata, z_m1_rdata};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_state_ws0 got=%h exp=%h", got, exp);
    end
    cpu_reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge cpu_clk); #1;
      checks++;
      if ({busy, m0_ack, m1_ack} !== 3'b000) begin
        failures++;
        $display("FAIL idle_after_reset cyc=%0d got=%b exp=000", i, {busy, m0_ack, m1_ack});
      end
    end
  endtask

  task automatic test_read();
    logic [4:0] ev [5] = '{5'b11100, 5'b10100, 5'b10100, 5'b11110, 5'b01100};
    logic [4:0] got;
    m0_we = 1'b0; m0_addr = 16'h1000; m0_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge cpu_clk); #1;
      if (i == 3) m0_req = 1'b0;
      got = {busy, mem_oe_n, mem_we_n, m0_ack, m1_ack};
      checks++;
      if (got !== ev[i]) begin
        failures++;
        $display("FAIL read_cycle%0d got=%b exp=%b", i, got, ev[i]);
      end
      if (i == 0) begin
        checks++;
        if (mem_addr !== 16'h1000) begin
          failures++;
          $display("FAIL read_addr got=%h exp=1000", mem_addr);
        end
      end
    end
    checks++;
    if (m0_rdata !== 8'h8E) begin
      failures++;
      $display("FAIL read_rdata got=%h exp=8e", m0_rdata);
    end
  endtask

  task automatic test_write();
    logic [4:0] ev [5] = '{5'b11100, 5'b11000, 5'b11000, 5'b11101, 5'b01100};
    logic [4:0] got;
    m1_we = 1'b1; m1_addr = 16'h0102; m1_wdata = 8'h01; m1_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge cpu_clk); #1;
      got = {busy, mem_oe_n, mem_we_n, m0_ack, m1_ack};
      checks++;
      if (got !== ev[i]) begin
        failures++;
        $display("FAIL write_cycle%0d got=%b exp=%b", i, got, ev[i]);
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 24'h010201) begin
        failures++;
        $display("FAIL write_addr_data cyc=%0d got=%h exp=010201", i, {mem_addr, mem_wdata});
      end
      // Requester withdraws and scribbles its inputs right after the grant.
      if (i == 0) begin
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'hFFFF; m1_wdata = 8'hFF;
      end
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 16'h8E00) begin
      failures++;
      $display("FAIL write_rdata_untouched got=%h exp=8e00", {m0_rdata, m1_rdata});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] got;
    logic [2:0] exp;
    cpu_reset_n = 1'b0;
    @(posedge cpu_clk); #1;
    cpu_reset_n = 1'b1;
    m0_we = 1'b0; m0_addr = 16'h1000;
    m1_we = 1'b0; m1_addr = 16'h2000;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge cpu_clk); #1;
      got = {m0_ack, m1_ack, mem_oe_n | mem_we_n};
      exp = {(i == 3 || i == 13), (i == 8 || i == 18), 1'b1};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rr_cycle%0d got=%b exp=%b", i, got, exp);
      end
      if (i == 18) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 16'h8EBE) begin
      failures++;
      $display("FAIL rr_rdata got=%h exp=8ebe", {m0_rdata, m1_rdata});
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ev [8] = '{5'b11100, 5'b10100, 5'b11110, 5'b01100,
                           5'b11100, 5'b10100, 5'b11110, 5'b01100};
    logic [4:0] got;
    logic [7:0] exp_rd;
    z_m0_we = 1'b0; z_m0_addr = 16'h0010; z_m0_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge cpu_clk); #1;
      got = {z_busy, z_mem_oe_n, z_mem_we_n, z_m0_ack, z_m1_ack};
      checks++;
      if (got !== ev[i]) begin
        failures++;
        $display("FAIL b2b_cycle%0d got=%b exp=%b", i, got, ev[i]);
      end
      exp_rd = (i < 2) ? 8'h00 : (i < 6) ? 8'h60 : 8'h61;
      checks++;
      if (z_m0_rdata !== exp_rd) begin
        failures++;
        $display("FAIL b2b_rdata cyc=%0d got=%h exp=%h", i, z_m0_rdata, exp_rd);
      end
      if (i == 0 || i == 4) begin
        checks++;
        if (z_mem_addr !== ((i == 0) ? 16'h0010 : 16'h0011)) begin
          failures++;
          $display("FAIL b2b_addr cyc=%0d got=%h", i, z_mem_addr);
        end
      end
      if (i == 2) z_m0_addr = 16'h0011;
      if (i == 6) z_m0_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] ev [2] = '{5'b11100, 5'b11000};
    logic [4:0] got;
    logic [44:0] rgot;
    m1_we = 1'b1; m1_addr = 16'h0304; m1_wdata = 8'h5A; m1_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge cpu_clk); #1;
      got = {busy, mem_oe_n, mem_we_n, m0_ack, m1_ack};
      checks++;
      if (got !== ev[i]) begin
        failures++;
        $display("FAIL rstmid_cycle%0d got=%b exp=%b", i, got, ev[i]);
      end
    end
    #2;
    cpu_reset_n = 1'b0;
    m1_req = 1'b0;
    #1;
    rgot = {busy, mem_oe_n, mem_we_n, m0_ack, m1_ack, mem_addr, mem_wdata, m0_rdata, m1_rdata};
    checks++;
    if (rgot !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 8'h0}) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h exp=%h", rgot,
               {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0, 8'h0});
    end
    @(posedge cpu_clk); #1;
    cpu_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge cpu_clk); #1;
      checks++;
      if ({busy, m0_ack, m1_ack, mem_we_n} !== 4'b0001) begin
        failures++;
        $display("FAIL rstmid_no_ack cyc=%0d got=%b exp=0001", i, {busy, m0_ack, m1_ack, mem_we_n});
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
